// File: rtl/calc_cordic_top.sv
// calc_cordic_top: multi-function iterative CORDIC calculator on signed Q16.16
// operands. One micro-rotation per clock on a single shared datapath that runs
// in circular, linear or hyperbolic mode, rotation or vectoring.
// Optional feature macro: CORDIC_HYPERBOLIC_EN compiles in hyperbolic mode and
// opcodes 9-14; without it those opcodes complete like DEFAULT with result 0.
module calc_cordic_top #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [3:0]              operation,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic signed [WIDTH-1:0] result,
  output logic                    done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_LOAD2, S_ITER2, S_FINISH} state_e;
  typedef enum logic [3:0] {
    OP_SIN, OP_COS, OP_TAN, OP_ATAN, OP_MAG, OP_PTR, OP_RTP, OP_MULT,
    OP_DIV, OP_SINH, OP_COSH, OP_ATANH, OP_EXP, OP_LOG, OP_SQRT, OP_DEF
  } op_e;
  typedef enum logic [1:0] {M_CIRC, M_LIN, M_HYP} mode_e;

  localparam logic signed [WIDTH-1:0] ONE   = WIDTH'(65536);
  localparam logic signed [WIDTH-1:0] INV_K = WIDTH'(39797);   // 1/K, circular gain
  localparam logic signed [WIDTH-1:0] PI    = WIDTH'(205887);
`ifdef CORDIC_HYPERBOLIC_EN
  localparam logic signed [WIDTH-1:0] INV_KH  = WIDTH'(79134); // 1/Kh, hyperbolic gain
  localparam logic signed [WIDTH-1:0] QUARTER = WIDTH'(16384);
`endif

  // Q16.16 x Q16.16 product, truncated (floor) back to Q16.16, wraps on overflow.
  function automatic logic signed [WIDTH-1:0] mul_q16_trunc(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    return WIDTH'(p >>> 16);
  endfunction

  // atan(2^-s) in Q16.16, rounded; for s >= 6 it equals 2^-s to the LSB.
  function automatic logic signed [WIDTH-1:0] atan_tab(input logic [4:0] s);
    logic signed [WIDTH-1:0] e;
    case (s)
      5'd0:    e = WIDTH'(51472);
      5'd1:    e = WIDTH'(30386);
      5'd2:    e = WIDTH'(16055);
      5'd3:    e = WIDTH'(8150);
      5'd4:    e = WIDTH'(4091);
      5'd5:    e = WIDTH'(2047);
      default: e = ONE >>> s;
    endcase
    return e;
  endfunction

`ifdef CORDIC_HYPERBOLIC_EN
  // atanh(2^-s) in Q16.16, rounded; s starts at 1, for s >= 6 it equals 2^-s.
  function automatic logic signed [WIDTH-1:0] atanh_tab(input logic [4:0] s);
    logic signed [WIDTH-1:0] e;
    case (s)
      5'd1:    e = WIDTH'(35999);
      5'd2:    e = WIDTH'(16739);
      5'd3:    e = WIDTH'(8235);
      5'd4:    e = WIDTH'(4101);
      5'd5:    e = WIDTH'(2049);
      default: e = ONE >>> s;
    endcase
    return e;
  endfunction

  // Hyperbolic shift for step i: 1,2,3,4,4,5,...,13,13,14 (repeats 4 and 13
  // so the series of atanh angles still covers every residual).
  function automatic logic [4:0] hyp_shift(input logic [4:0] i);
    logic [4:0] s;
    s = i + 5'd1;
    if (i >= 5'd4)  s = s - 5'd1;
    if (i >= 5'd14) s = s - 5'd1;
    return s;
  endfunction
`endif

  state_e                  state, state_nx;
  op_e                     op_r;
  logic signed [WIDTH-1:0] xin_r, yin_r, zin_r;
  logic signed [WIDTH-1:0] x_r, y_r, z_r;
  logic [4:0]              iter_cnt;
  mode_e                   mode;
  logic                    vec;
  logic [4:0]              sh;
  logic signed [WIDTH-1:0] ang, x_sh, y_sh;
  logic                    d_pos;
  logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;
  logic signed [WIDTH-1:0] x_ld, y_ld, z_ld;
  logic signed [WIDTH-1:0] res_val;
  logic                    no_iter;
  logic                    last_iter;

`ifdef CORDIC_HYPERBOLIC_EN
  assign no_iter = (op_r == OP_DEF);
`else
  assign no_iter = (op_r >= OP_SINH);
`endif
  assign last_iter = (iter_cnt == 5'(ITERATIONS - 1));

  // State register and captured opcode
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_r  <= OP_DEF;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && enable) op_r <= op_e'(operation);
    end
  end

  // Next-state: TAN chains a linear vectoring pass after its sin/cos pass
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (enable) state_nx = S_LOAD;
      S_LOAD:   state_nx = no_iter ? S_FINISH : S_ITER;
      S_ITER:   if (last_iter) state_nx = (op_r == OP_TAN) ? S_LOAD2 : S_FINISH;
      S_LOAD2:  state_nx = S_ITER2;
      S_ITER2:  if (last_iter) state_nx = S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Operand capture; later input changes are ignored until the next start
  always_ff @(posedge clk) begin
    if (state == S_IDLE && enable) begin
      xin_r <= x_in;
      yin_r <= y_in;
      zin_r <= z_in;
    end
  end

  // Coordinate system and direction rule for the current pass
  always_comb begin
    mode = M_CIRC;
    vec  = 1'b0;
    if (state == S_ITER2) begin
      mode = M_LIN;
      vec  = 1'b1;
    end else begin
      case (op_r)
        OP_ATAN, OP_MAG, OP_RTP: vec = 1'b1;
        OP_MULT:                 mode = M_LIN;
        OP_DIV:                  begin mode = M_LIN; vec = 1'b1; end
`ifdef CORDIC_HYPERBOLIC_EN
        OP_SINH, OP_COSH, OP_EXP:  mode = M_HYP;
        OP_ATANH, OP_LOG, OP_SQRT: begin mode = M_HYP; vec = 1'b1; end
`endif
        default: ;
      endcase
    end
  end

  // One micro-rotation; d=+1 when z>=0 (rotation) or y<0 (vectoring)
  always_comb begin
    sh  = iter_cnt;
    ang = atan_tab(iter_cnt);
`ifdef CORDIC_HYPERBOLIC_EN
    if (mode == M_HYP) begin
      sh  = hyp_shift(iter_cnt);
      ang = atanh_tab(sh);
    end
`endif
    if (mode == M_LIN) ang = ONE >>> iter_cnt;
    x_sh  = x_r >>> sh;
    y_sh  = y_r >>> sh;
    d_pos = vec ? y_r[WIDTH-1] : ~z_r[WIDTH-1];
    y_nx  = d_pos ? y_r + x_sh : y_r - x_sh;
    z_nx  = d_pos ? z_r - ang  : z_r + ang;
    case (mode)
      M_CIRC:  x_nx = d_pos ? x_r - y_sh : x_r + y_sh;
      M_HYP:   x_nx = d_pos ? x_r + y_sh : x_r - y_sh;
      default: x_nx = x_r;
    endcase
  end

  // Initial x/y/z for the first pass of each operation
  always_comb begin
    x_ld = '0;
    y_ld = '0;
    z_ld = '0;
    case (op_r)
      OP_SIN, OP_COS, OP_TAN:  begin x_ld = INV_K; z_ld = zin_r; end
      OP_ATAN, OP_MAG, OP_DIV: begin x_ld = xin_r; y_ld = yin_r; end
      OP_PTR:                  begin x_ld = mul_q16_trunc(xin_r, INV_K); z_ld = zin_r; end
      OP_RTP: begin
        // Left half-plane: rotate by pi first so vectoring stays convergent
        if (xin_r[WIDTH-1]) begin
          x_ld = -xin_r;
          y_ld = -yin_r;
          z_ld = yin_r[WIDTH-1] ? -PI : PI;
        end else begin
          x_ld = xin_r;
          y_ld = yin_r;
        end
      end
      OP_MULT:                 begin x_ld = xin_r; z_ld = zin_r; end
`ifdef CORDIC_HYPERBOLIC_EN
      OP_SINH, OP_COSH, OP_EXP: begin x_ld = INV_KH; z_ld = zin_r; end
      OP_ATANH:                 begin x_ld = xin_r; y_ld = yin_r; end
      OP_LOG:                   begin x_ld = xin_r + ONE; y_ld = xin_r - ONE; end
      OP_SQRT:                  begin x_ld = xin_r + QUARTER; y_ld = xin_r - QUARTER; end
`endif
      default: ;
    endcase
  end

  // Result selection from the final x/y/z
  always_comb begin
    res_val = '0;
    case (op_r)
      OP_SIN, OP_MULT:                res_val = y_r;
      OP_COS, OP_PTR:                 res_val = x_r;
      OP_TAN, OP_ATAN, OP_RTP, OP_DIV: res_val = z_r;
      OP_MAG:                         res_val = mul_q16_trunc(x_r, INV_K);
`ifdef CORDIC_HYPERBOLIC_EN
      OP_SINH:                        res_val = y_r;
      OP_COSH:                        res_val = x_r;
      OP_ATANH:                       res_val = z_r;
      OP_EXP:                         res_val = x_r + y_r;
      OP_LOG:                         res_val = z_r <<< 1;
      OP_SQRT:                        res_val = mul_q16_trunc(x_r, INV_KH);
`endif
      default: ;
    endcase
  end

  // Datapath registers, iteration counter and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      iter_cnt <= '0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_LOAD: begin
          x_r      <= x_ld;
          y_r      <= y_ld;
          z_r      <= z_ld;
          iter_cnt <= '0;
        end
        S_ITER, S_ITER2: begin
          x_r      <= x_nx;
          y_r      <= y_nx;
          z_r      <= z_nx;
          iter_cnt <= iter_cnt + 5'd1;
        end
        S_LOAD2: begin
          z_r      <= '0;
          iter_cnt <= '0;
        end
        S_FINISH: begin
          result <= res_val;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cordic_top.sv
// Bench for calc_cordic_top: directed vector table, hand-written multi-cycle
// sequences and randomized operations against a real-arithmetic model.
module tb_calc_cordic_top;

  localparam int N = 16;
`ifdef CORDIC_HYPERBOLIC_EN
  localparam bit HYP = 1'b1;
`else
  localparam bit HYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [3:0]         operation;
  logic signed [31:0] x_in, y_in, z_in;
  logic signed [31:0] result;
  logic               done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] op;
    int         x;
    int         y;
    int         z;
    int         expv;
    int         tol;
  } vec_t;

  vec_t               tbl[17];
  int                 cnt, first, lat;
  logic signed [31:0] res;
  bit                 seen;
  logic [3:0]         rop;
  int                 rx, ry, rz;

  always #5 clk = ~clk;

  calc_cordic_top #(.WIDTH(32), .ITERATIONS(N)) dut (
    .clk(clk), .rst(rst), .enable(enable), .operation(operation),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .result(result), .done(done)
  );

  function automatic bit no_iter_op(input logic [3:0] op);
    return (op == 4'd15) || (op >= 4'd9 && !HYP);
  endfunction

  function automatic int exp_latency(input logic [3:0] op);
    if (no_iter_op(op)) return 2;
    if (op == 4'd2) return 2 * N + 3;
    return N + 2;
  endfunction

  // Mathematical meaning of each opcode, in real arithmetic
  function automatic int ref_result(input logic [3:0] op, input int x, input int y, input int z);
    real xr, yr, zr, r;
    xr = x / 65536.0;
    yr = y / 65536.0;
    zr = z / 65536.0;
    r  = 0.0;
    if (no_iter_op(op)) return 0;
    case (op)
      4'd0:  r = $sin(zr);
      4'd1:  r = $cos(zr);
      4'd2:  r = $tan(zr);
      4'd3:  r = $atan2(yr, xr);
      4'd4:  r = $sqrt(xr * xr + yr * yr);
      4'd5:  r = xr * $cos(zr);
      4'd6:  r = $atan2(yr, xr);
      4'd7:  r = xr * zr;
      4'd8:  r = yr / xr;
      4'd9:  r = $sinh(zr);
      4'd10: r = $cosh(zr);
      4'd11: r = $atanh(yr / xr);
      4'd12: r = $exp(zr);
      4'd13: r = $ln(xr);
      4'd14: r = $sqrt(xr);
      default: r = 0.0;
    endcase
    return $rtoi(r * 65536.0 + ((r >= 0.0) ? 0.5 : -0.5));
  endfunction

  function automatic int q(input real v);
    return $rtoi(v * 65536.0);
  endfunction

  function automatic real urnd(input real lo, input real hi);
    return lo + (hi - lo) * ($urandom_range(0, 100000) / 100000.0);
  endfunction

  task automatic check(input string name, input longint act, input longint expv, input longint tol);
    longint diff;
    diff = act - expv;
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, expv, tol);
    end
  endtask

  // Present a command for one edge, then scramble the inputs
  task automatic pulse_start(input logic [3:0] op, input int x, input int y, input int z);
    @(negedge clk);
    operation = op;
    x_in      = x;
    y_in      = y;
    z_in      = z;
    enable    = 1'b1;
    @(posedge clk);
    #1;
    enable    = 1'b0;
    operation = 4'($urandom);
    x_in      = $urandom;
    y_in      = $urandom;
    z_in      = $urandom;
  endtask

  task automatic wait_done(output int l, output logic signed [31:0] r, output bit s);
    int n;
    l = 0;
    r = '0;
    s = 1'b0;
    n = 0;
    while (!s && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        s = 1'b1;
        l = n;
        r = result;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input int x, input int y,
                        input int z, input int expv, input int tol);
    int                 l;
    logic signed [31:0] r;
    bit                 s;
    pulse_start(op, x, y, z);
    wait_done(l, r, s);
    check({name, "_latency"}, l, exp_latency(op), 0);
    check({name, "_result"}, r, expv, tol);
    @(posedge clk);
    #1;
    check({name, "_pulse_width"}, done, 0, 0);
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    operation = '0;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 0, 0);
    check("reset_done", done, 0, 0);
    rst = 1'b0;

    // Directed vectors: op, x, y, z, expected, tolerance
    tbl[0]  = '{4'd0,  0,       0,      51471,  46341,  131};
    tbl[1]  = '{4'd1,  0,       0,      51471,  46341,  131};
    tbl[2]  = '{4'd2,  0,       0,      51471,  65536,  131};
    tbl[3]  = '{4'd3,  65536,   65536,  0,      51472,  131};
    tbl[4]  = '{4'd4,  196608,  262144, 0,      327680, 131};
    tbl[5]  = '{4'd5,  131072,  0,      68629,  65536,  131};
    tbl[6]  = '{4'd6,  -65536,  65536,  0,      154415, 131};
    tbl[7]  = '{4'd6,  -65536,  -65536, 0,      -154415, 131};
    tbl[8]  = '{4'd7,  98304,   0,      131072, 196608, 131};
    tbl[9]  = '{4'd8,  589824,  983040, 0,      109227, 131};
    tbl[10] = '{4'd9,  0,       0,      65536,  HYP ? 77018  : 0, HYP ? 131 : 0};
    tbl[11] = '{4'd10, 0,       0,      65536,  HYP ? 101127 : 0, HYP ? 131 : 0};
    tbl[12] = '{4'd11, 65536,   32768,  0,      HYP ? 35999  : 0, HYP ? 131 : 0};
    tbl[13] = '{4'd12, 0,       0,      65536,  HYP ? 178145 : 0, HYP ? 131 : 0};
    tbl[14] = '{4'd13, 131072,  0,      0,      HYP ? 45426  : 0, HYP ? 131 : 0};
    tbl[15] = '{4'd14, 131072,  0,      0,      HYP ? 92682  : 0, HYP ? 131 : 0};
    tbl[16] = '{4'd15, 12345,   -6789,  65536,  0,      0};

    for (int i = 0; i < 17; i++)
      run_op($sformatf("vec%0d_op%0d", i, tbl[i].op), tbl[i].op, tbl[i].x, tbl[i].y,
             tbl[i].z, tbl[i].expv, tbl[i].tol);

    // enable pulsed while busy: ignored, exactly one done
    pulse_start(4'd7, 98304, 0, 131072);
    cnt   = 0;
    first = 0;
    res   = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      enable    = (n == 4);
      operation = 4'd15;
      @(posedge clk);
      #1;
      if (done) begin
        cnt++;
        if (first == 0) first = n;
        res = result;
      end
    end
    enable = 1'b0;
    check("busy_done_count", cnt, 1, 0);
    check("busy_latency", first, exp_latency(4'd7), 0);
    check("busy_result", res, 196608, 131);

    // back-to-back: next start on the cycle right after FINISH
    pulse_start(4'd0, 0, 0, 51471);
    wait_done(lat, res, seen);
    check("b2b_first_latency", lat, N + 2, 0);
    pulse_start(4'd1, 0, 0, -51471);
    wait_done(lat, res, seen);
    check("b2b_second_latency", lat, N + 2, 0);
    check("b2b_second_result", res, 46341, 131);

    // reset at iteration 5 aborts: no done, result cleared
    pulse_start(4'd0, 0, 0, 51471);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_result", result, 0, 0);
    check("midrst_done", done, 0, 0);
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("midrst_no_done", cnt, 0, 0);
    run_op("post_reset_sin", 4'd0, 0, 0, -51471, -46341, 131);

    // Randomized operations within each opcode's convergence range
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      rx  = 0;
      ry  = 0;
      rz  = 0;
      case (rop)
        4'd0, 4'd1: rz = q(urnd(-1.5, 1.5));
        4'd2:       rz = q(urnd(-1.0, 1.0));
        4'd3, 4'd4: begin rx = q(urnd(0.25, 4.0)); ry = q(urnd(-4.0, 4.0)); end
        4'd5:       begin rx = q(urnd(0.0, 4.0)); rz = q(urnd(-1.5, 1.5)); end
        4'd6: begin
          rx = q(urnd(-4.0, 4.0));
          ry = q(urnd(-4.0, 4.0));
          if (rx > -16384 && rx < 16384 && ry > -16384 && ry < 16384) rx = 65536;
        end
        4'd7:       begin rx = q(urnd(-4.0, 4.0)); rz = q(urnd(-1.9, 1.9)); end
        4'd8:       begin rx = q(urnd(1.0, 4.0)); ry = q(urnd(-1.8, 1.8) * (rx / 65536.0)); end
        4'd9, 4'd10, 4'd12: rz = q(urnd(-1.0, 1.0));
        4'd11:      begin rx = q(urnd(0.5, 2.0)); ry = q(urnd(-0.7, 0.7) * (rx / 65536.0)); end
        4'd13:      rx = q(urnd(0.5, 4.0));
        4'd14:      rx = q(urnd(0.15, 1.8));
        default:    begin rx = $urandom; ry = $urandom; rz = $urandom; end
      endcase
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, rx, ry, rz,
             ref_result(rop, rx, ry, rz), no_iter_op(rop) ? 0 : 131);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_cordic_top.md
# calc_cordic_top

Multi-function iterative CORDIC calculator (RTL module `calc_cordic_top`). It executes one of fifteen trigonometric, linear or hyperbolic operations on signed Q16.16 operands and returns a single Q16.16 result. It uses one shared rotation datapath that performs one micro-rotation per clock. It sits behind a register/command front end that loads operands, pulses `enable`, and waits for `done`.

## Interface
- `WIDTH`, 32, datapath/operand width; format Q(WIDTH-16).16; only 32 must be supported.
- `ITERATIONS`, 16, micro-rotations per CORDIC pass; legal range 8..16.
- `clk` in 1 – single clock; all logic on rising edge.
- `rst` in 1 – reset, synchronous, active-high.
- `enable` in 1 – start command; sampled only in IDLE.
- `operation` in 4 – opcode: 0 SIN, 1 COS, 2 TAN, 3 ATAN, 4 MAG, 5 POLtoREC, 6 RECtoPOL, 7 MULT, 8 DIV, 9 SINH, 10 COSH, 11 ATANH, 12 EXP, 13 LOG, 14 SQRT, 15 DEFAULT.
- `x_in`, `y_in`, `z_in` in WIDTH – signed Q16.16 operands; angles in radians.
- `result` out WIDTH – signed Q16.16 result; holds until next completion.
- `done` out 1 – one-cycle completion pulse.

## Operation
- States: IDLE → LOAD → ITER (ITERATIONS cycles) → [TAN only: LOAD2 → ITER2] → FINISH → IDLE.
- In IDLE with `enable`=1, operands and opcode are registered. Later input changes are ignored.
- Micro-rotation i: d = sign(z) (rotation) or −sign(y) (vectoring). x' = x − m·d·(y>>>s), y' = y + d·(x>>>s), z' = z − d·e(s). Shifts are arithmetic.
  - Circular m=+1, s=i, e=atan(2^-i).
  - Linear m=0, s=i, e=2^-i.
  - Hyperbolic m=−1, s sequence 1,2,3,4,4,5,…,13,13,14…; exactly ITERATIONS steps; e=atanh(2^-s).
- Angle tables: Q16.16 constants rounded to nearest. 1/K=0.607253 (39797). 1/Kh=1.207497 (79134).
- Init / result mapping:
  - SIN/COS: circular rotation, x=1/K, y=0, z=z_in. Result y (SIN) or x (COS). Valid for |z|≤π/2.
  - TAN: SIN/COS pass, then linear vectoring x=cos, y=sin, z=0. Result z.
  - ATAN: circular vectoring x=x_in, y=y_in, z=0. Result z. Requires x_in>0.
  - MAG: same as ATAN. Result x·(1/K) via one constant multiply, truncated to Q16.16.
  - POLtoREC: rotation x=x_in·(1/K), y=0, z=z_in. Result x (r·cosθ).
  - RECtoPOL: atan2(y_in,x_in) over full plane. If x_in<0, pre-rotate by ±π (negate x,y; z starts ±π by sign of y_in). Result z.
  - MULT: linear rotation x=x_in, y=0, z=z_in. Result y = x·z. |z_in|<2.
  - DIV: linear vectoring x=x_in, y=y_in, z=0. Result z = y/x. |y/x|<2, x_in>0.
  - SINH/COSH: hyperbolic rotation x=1/Kh, y=0, z=z_in. Result y (SINH) or x (COSH). |z|≤1.118.
  - EXP: as SINH. Result x+y.
  - ATANH: hyperbolic vectoring x=x_in, y=y_in. Result z.
  - LOG: vectoring x=x_in+1, y=x_in−1. Result 2z (ln x_in).
  - SQRT: vectoring x=x_in+0.25, y=x_in−0.25. Result x·(1/Kh).
  - DEFAULT: no iterations; result 0.
- Out-of-range inputs give unspecified but finite values. No saturation; wrap-around on overflow.

## Timing
- Reset: state IDLE, `result`=0, `done`=0, internal x/y/z/counter=0.
- `enable` sampled at edge E. LOAD at E+1, ITER cycles E+2..E+1+ITERATIONS, FINISH registers `result` and `done`=1.
- Latency: `done` high during cycle E+ITERATIONS+2 (18 cycles at default). TAN adds ITERATIONS+1. DEFAULT: E+2.
- `done` is high exactly one cycle. `result` updates on the same edge `done` rises.
- `enable` while busy is ignored; no queueing. Back-to-back starts are allowed the cycle after FINISH.
- `rst` mid-operation aborts immediately; no `done` pulse.

## Configuration
- `CORDIC_HYPERBOLIC_EN` defined: hyperbolic mode, Kh constant, atanh table and opcodes 9–14 are compiled in.
- Not defined: hyperbolic hardware is absent. Opcodes 9–14 behave exactly as DEFAULT (result 0, `done` at E+2).

## Test plan
Tolerance ±0.002 (131 LSB) unless noted; macro defined.
- SIN, z_in=0.7854 (51471) → result ≈0.7071 (46341); `done` exactly 18 cycles after `enable` edge.
- COS z=0.7854 → ≈0.7071. MULT x=1.5, z=2.0 → ≈3.0. DIV x=9, y=15 → ≈1.6667.
- SINH z=1.0 → ≈1.1752. COSH z=1.0 → ≈1.5431. EXP z=1.0 → ≈2.7183.
- TAN z=0.7854 → ≈1.0 (latency 35). MAG x=3, y=4 → ≈5.0. RECtoPOL x=−1, y=1 → ≈2.3562. SQRT x=2 → ≈1.4142.
- Assert `rst` at iteration 5 → no `done`, result 0. `enable` pulsed while busy → ignored, single `done`. DEFAULT → result 0, latency 2.
- Macro undefined: SINH z=1.0 → result 0, `done` at E+2.
